// File: rtl/dual_rail_link_if.sv
// Word-level handshake bundle for dual_rail_link: sender-side request/data
// and receiver-side decoded word.
interface dual_rail_link_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] inj;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;

  modport master (
    output tx_data, tx_valid, inj,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, inj,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/dual_rail_link.sv
// WIDTH-bit four-phase dual-rail link: sender FSM drives rail pairs, receiver
// performs completion detection and returns ack; adds error flags and a word counter.
module dual_rail_link #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15,
  parameter int CW      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dual_rail_link_if.slave       lnk,
  output logic [WIDTH-1:0]      rail0,
  output logic [WIDTH-1:0]      rail1,
  output logic                  ack,
  output logic                  code_err,
  output logic                  timeout_err,
  output logic [CW-1:0]         word_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    SPACER = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [TW-1:0]    wait_r;
  logic [WIDTH-1:0] rail0_r, rail1_r, rail0_s, rail1_s;
  logic             tx_ready_r;
  logic             timeout_err_r, to_set_s;
  logic             accept_s, wait_hit_s;
  logic             ack_r, rx_valid_r, code_err_r;
  logic [WIDTH-1:0] rx_data_r;
  logic [CW-1:0]    word_count_r;
  logic             complete_s, empty_s, illegal_s;

  function automatic logic pair_complete(input logic [WIDTH-1:0] r0, input logic [WIDTH-1:0] r1);
    return &(r0 ^ r1);
  endfunction

  function automatic logic pair_empty(input logic [WIDTH-1:0] r0, input logic [WIDTH-1:0] r1);
    return ~|(r0 | r1);
  endfunction

  function automatic logic pair_illegal(input logic [WIDTH-1:0] r0, input logic [WIDTH-1:0] r1);
    return |(r0 & r1);
  endfunction

  assign accept_s   = lnk.tx_valid & tx_ready_r;
  assign wait_hit_s = (wait_r == TW'(TIMEOUT - 1));
  assign complete_s = pair_complete(rail0_r, rail1_r);
  assign empty_s    = pair_empty(rail0_r, rail1_r);
  assign illegal_s  = pair_illegal(rail0_r, rail1_r);

  // Sender state, wait counter and registered sender outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      wait_r        <= {TW{1'b0}};
      rail0_r       <= {WIDTH{1'b0}};
      rail1_r       <= {WIDTH{1'b0}};
      tx_ready_r    <= 1'b1;
      timeout_err_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      rail0_r    <= rail0_s;
      rail1_r    <= rail1_s;
      tx_ready_r <= (state_s == IDLE);
      if (state_s != state_r) begin
        wait_r <= {TW{1'b0}};
      end else if (state_r != IDLE) begin
        wait_r <= wait_r + {{(TW-1){1'b0}}, 1'b1};
      end else begin
        wait_r <= {TW{1'b0}};
      end
      if (to_set_s) begin
        timeout_err_r <= 1'b1;
      end else begin
        timeout_err_r <= timeout_err_r;
      end
    end
  end

  // Sender next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = DATA;
        else          state_s = IDLE;
      end
      DATA: begin
        if (ack_r || wait_hit_s) state_s = SPACER;
        else                     state_s = DATA;
      end
      SPACER: begin
        if (!ack_r || wait_hit_s) state_s = IDLE;
        else                      state_s = SPACER;
      end
      default: state_s = IDLE;
    endcase
  end

  // Sender rail drive and timeout flagging; an ack arriving on the timeout
  // cycle takes priority so it is not reported as an error.
  always_comb begin
    rail0_s  = rail0_r;
    rail1_s  = rail1_r;
    to_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          rail0_s = ~lnk.tx_data | lnk.inj;
          rail1_s =  lnk.tx_data | lnk.inj;
        end else begin
          rail0_s = {WIDTH{1'b0}};
          rail1_s = {WIDTH{1'b0}};
        end
      end
      DATA: begin
        if (ack_r) begin
          rail0_s = {WIDTH{1'b0}};
          rail1_s = {WIDTH{1'b0}};
        end else if (wait_hit_s) begin
          rail0_s  = {WIDTH{1'b0}};
          rail1_s  = {WIDTH{1'b0}};
          to_set_s = 1'b1;
        end else begin
          rail0_s = rail0_r;
          rail1_s = rail1_r;
        end
      end
      SPACER: begin
        rail0_s = {WIDTH{1'b0}};
        rail1_s = {WIDTH{1'b0}};
        if (!ack_r) to_set_s = 1'b0;
        else        to_set_s = wait_hit_s;
      end
      default: begin
        rail0_s = {WIDTH{1'b0}};
        rail1_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // Receiver: completion/spacer detection, ack, decoded word and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r        <= 1'b0;
      rx_valid_r   <= 1'b0;
      rx_data_r    <= {WIDTH{1'b0}};
      word_count_r <= {CW{1'b0}};
      code_err_r   <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      if (!ack_r && complete_s) begin
        ack_r        <= 1'b1;
        rx_data_r    <= rail1_r;
        rx_valid_r   <= 1'b1;
        word_count_r <= word_count_r + {{(CW-1){1'b0}}, 1'b1};
      end else if (ack_r && empty_s) begin
        ack_r <= 1'b0;
      end else begin
        ack_r <= ack_r;
      end
      if (illegal_s) begin
        code_err_r <= 1'b1;
      end else begin
        code_err_r <= code_err_r;
      end
    end
  end

  assign lnk.tx_ready = tx_ready_r;
  assign lnk.rx_data  = rx_data_r;
  assign lnk.rx_valid = rx_valid_r;
  assign rail0        = rail0_r;
  assign rail1        = rail1_r;
  assign ack          = ack_r;
  assign code_err     = code_err_r;
  assign timeout_err  = timeout_err_r;
  assign word_count   = word_count_r;

endmodule

// File: doc/dual_rail_link.md
# dual_rail_link

Parametrised successor to the single-bit dual-rail sender/receiver channel. It carries WIDTH-bit words across an internal dual-rail, four-phase (return-to-zero) link: a sender FSM encodes each word onto rail0/rail1 pairs, and a receiver performs completion detection and drives the ack. The rails and ack are exported for observation. The block adds a word-level valid/ready interface, spacer enforcement, illegal-code detection, ack timeout and a received-word counter, none of which the 1-bit channel has.

## Interface
- WIDTH, 8: data bits per word; number of rail pairs; ≥1.
- TIMEOUT, 15: maximum cycles the sender waits for an ack edge before it flags an error; ≥2.
- CW, 16: width of word_count.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset is asynchronous and active-high.
- tx_data  input  WIDTH  word to send; sampled on accept.
- tx_valid  input  1  sender request.
- tx_ready  output  1  high only in IDLE. Accept happens when tx_valid and tx_ready are both high.
- inj  input  WIDTH  test hook, sampled on accept. A set bit i drives rail0[i] and rail1[i] both high in DATA.
- rx_data  output  WIDTH  last decoded word; holds until the next completion.
- rx_valid  output  1  one-cycle pulse when a word completes.
- rail0, rail1  output  WIDTH each  registered dual-rail link. Bit i = 0 is encoded rail0=1, rail1=0; bit i = 1 is rail0=0, rail1=1; spacer is both 0.
- ack  output  1  registered receiver acknowledge.
- code_err  output  1  sticky; a rail pair was seen with both rails high.
- timeout_err  output  1  sticky; ack did not arrive within TIMEOUT cycles.
- word_count  output  CW  number of completed words, modulo 2^CW.

## Operation
- Reset values: all outputs 0 except tx_ready = 1. Sender is in IDLE. Timeout counter is 0.
- Sender FSM states: IDLE, DATA, SPACER.
  - IDLE: tx_ready=1. On accept, load the rails from tx_data and inj, then go to DATA.
  - DATA: hold the rails. If ack=1, clear the rails to spacer and go to SPACER. If the wait counter reaches TIMEOUT, set timeout_err, clear the rails to spacer and go to SPACER.
  - SPACER: rails are all 0. If ack=0, go to IDLE. If the wait counter reaches TIMEOUT, set timeout_err and go to IDLE.
- Wait counter: cleared on every state change; increments each cycle spent in DATA or SPACER.
- Receiver, evaluated each cycle on the registered rails:
  - complete = every pair has exactly one rail high.
  - empty = all rails 0.
  - illegal = any pair has both rails high.
  - If ack=0 and complete: ack←1, rx_data←rail1, rx_valid←1, word_count←word_count+1 (wraps).
  - If ack=1 and empty: ack←0.
  - If illegal: code_err←1. ack does not rise while any pair is illegal.
  - Partial codewords (some pairs still at spacer) cause no action.
- Errors are sticky and are cleared only by rst. They do not block further traffic.
- rst asserted mid-transfer: rails, ack and FSM return to their reset values immediately (asynchronously). No rx_valid pulse is produced for the word in flight.

## Timing
- Accept at edge n. Rails are valid from n+1. ack=1 and the rx_valid pulse occur at n+2. Rails return to spacer at n+3. ack=0 at n+4. tx_ready=1 at n+5.
- Accept-to-rx_valid latency: 2 cycles.
- Throughput: one word per 5 cycles when tx_valid is held high.
- tx_ready is low from n+1 to n+4 inclusive. tx_valid asserted during that window is ignored and is not queued.
- Timeout path (ack never rises): DATA lasts TIMEOUT cycles, then spacer. SPACER exits after one cycle because ack is already 0. tx_ready returns TIMEOUT+2 cycles after accept.
- rx_data and word_count change only in the cycle in which rx_valid pulses.

## Test plan
- Reset then single word: tx_data=8'hA5 with one accept. Required: rail1=8'hA5 and rail0=8'h5A at n+1; rx_valid pulse at n+2 with rx_data=8'hA5; word_count=1; tx_ready high at n+5.
- Back-to-back traffic: send 8'h00, 8'hFF, 8'h3C with tx_valid held high. Required: rx_valid pulses 5 cycles apart with those values in order; word_count=3; no error flags set.
- Illegal code: send with inj=8'h01. Required: rail0[0]=rail1[0]=1 at n+1; code_err=1 at n+2; ack stays 0; timeout_err=1 at n+1+TIMEOUT; no rx_valid pulse; the next clean word (8'h11) is received correctly while both errors stay 1.
- Counter wrap: CW=4, send 17 words. Required: word_count reads 0xF after word 15, 0x0 after word 16, 0x1 after word 17.
- Reset mid-operation: assert rst for 1 cycle at n+1, while the rails are valid. Required: rails, ack, rx_valid and word_count go to 0 immediately; tx_ready=1; no pulse is produced; the next transfer follows the normal 5-cycle timing.
- WIDTH=1 build: send 1, 0, 1. Required: rails follow the bit-level encoding; rx_data sequence is 1, 0, 1.
